// File: rtl/instruct_decoder.sv
// instruct_decoder -- RV32I decode stage.
// Splits the instruction word into its register/function fields, builds all
// five immediate formats and derives datapath control. Everything is
// registered, so a decode appears one clock after the instruction.
//
// Ports:
//   clk, rst_n          clock (rising edge) / synchronous active-low reset
//   instruction [31:0]  word to decode, accepted every cycle
//   opcode/rd/funct3/rs1/rs2/funct7   raw fields, extracted for any opcode
//   imm_I/S/B/U/J [31:0]              sign-extended immediates
//   reg_write, mem_read, mem_write, branch, jump, alu_op[3:0]   control
module instruct_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm_I,
  output logic [31:0] imm_S,
  output logic [31:0] imm_B,
  output logic [31:0] imm_U,
  output logic [31:0] imm_J,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic        branch,
  output logic        jump
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_op;
    logic        branch;
    logic        jump;
  } dec_t;

  dec_t       dec_d, dec_q;
  logic [3:0] arith_op;
  logic       alt;   // funct7[5]: selects SUB / SRA

  // Shared R/I funct3 map; `alt` is qualified per opcode by the caller.
  always_comb begin
    arith_op = ALU_ADD;
    case (instruction[14:12])
      3'b000: arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // For I-ALU only the shift uses funct7; ADDI never becomes SUB.
  assign alt = instruction[30] &
               ((instruction[6:0] == OP_R) | (instruction[14:12] == 3'b101));

  always_comb begin
    dec_d        = '0;
    dec_d.opcode = instruction[6:0];
    dec_d.rd     = instruction[11:7];
    dec_d.funct3 = instruction[14:12];
    dec_d.rs1    = instruction[19:15];
    dec_d.rs2    = instruction[24:20];
    dec_d.funct7 = instruction[31:25];
    dec_d.imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    dec_d.imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    dec_d.imm_b  = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
    dec_d.imm_u  = {instruction[31:12], 12'b0};
    dec_d.imm_j  = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};
    case (instruction[6:0])
      OP_R, OP_I: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_op    = arith_op;
      end
      OP_LOAD: begin
        dec_d.reg_write = 1'b1;
        dec_d.mem_read  = 1'b1;
      end
      OP_STORE: dec_d.mem_write = 1'b1;
      OP_BRANCH: begin
        dec_d.branch = 1'b1;
        case (instruction[14:13])
          2'b00:   dec_d.alu_op = ALU_SUB;   // BEQ/BNE
          2'b01:   dec_d.alu_op = ALU_ADD;   // reserved
          2'b10:   dec_d.alu_op = ALU_SLT;   // BLT/BGE
          default: dec_d.alu_op = ALU_SLTU;  // BLTU/BGEU
        endcase
      end
      OP_JAL, OP_JALR: begin
        dec_d.reg_write = 1'b1;
        dec_d.jump      = 1'b1;
      end
      OP_LUI: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_op    = ALU_PASS;
      end
      OP_AUIPC: dec_d.reg_write = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  assign opcode    = dec_q.opcode;
  assign rd        = dec_q.rd;
  assign funct3    = dec_q.funct3;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign funct7    = dec_q.funct7;
  assign imm_I     = dec_q.imm_i;
  assign imm_S     = dec_q.imm_s;
  assign imm_B     = dec_q.imm_b;
  assign imm_U     = dec_q.imm_u;
  assign imm_J     = dec_q.imm_j;
  assign reg_write = dec_q.reg_write;
  assign mem_read  = dec_q.mem_read;
  assign mem_write = dec_q.mem_write;
  assign alu_op    = dec_q.alu_op;
  assign branch    = dec_q.branch;
  assign jump      = dec_q.jump;

endmodule

// File: tb/tb_instruct_decoder.sv
// Bench for instruct_decoder: an instruction-level model predicts every
// output each cycle, plus literal expectations for hand-decoded instructions.
module tb_instruct_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_I, imm_S, imm_B, imm_U, imm_J;
  logic        reg_write, mem_read, mem_write, branch, jump;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  instruct_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm_I(imm_I), .imm_S(imm_S), .imm_B(imm_B),
    .imm_U(imm_U), .imm_J(imm_J), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
    .branch(branch), .jump(jump)
  );

  always #5 clk = ~clk;

  // Flattened view: fields, five immediates, then {rw,mr,mw,br,jp,alu}.
  typedef logic [7+5+3+5+5+7+160+9-1:0] vec_t;

  function automatic vec_t model(input logic [31:0] ins, input logic rstn);
    logic [31:0] ii, is, ib, iu, ij;
    logic [4:0]  ctl;
    logic [3:0]  alu;
    int          v;
    logic [3:0]  arith [8];
    logic [3:0]  brtab [8];
    int          f3;
    arith = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    brtab = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd3, 4'd3, 4'd4, 4'd4};
    if (!rstn) return '0;
    f3 = int'(ins[14:12]);
    ii = 32'($signed(ins) >>> 20);
    is = (ii & ~32'h1F) | 32'(ins[11:7]);
    v  = ins[31] ? -4096 : 0;
    v  = v + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    ib = 32'(v);
    iu = ins & 32'hFFFF_F000;
    v  = ins[31] ? -(1 << 20) : 0;
    v  = v + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    ij = 32'(v);
    ctl = 5'b0; alu = 4'd0;           // ctl = {rw, mr, mw, br, jp}
    case (ins[6:0])
      7'h33: begin ctl = 5'b10000; alu = arith[f3] + 4'((f3 == 0 || f3 == 5) && ins[30]); end
      7'h13: begin ctl = 5'b10000; alu = arith[f3] + 4'(f3 == 5 && ins[30]); end
      7'h03: ctl = 5'b11000;
      7'h23: ctl = 5'b00100;
      7'h63: begin ctl = 5'b00010; alu = brtab[f3]; end
      7'h6F, 7'h67: ctl = 5'b10001;
      7'h37: begin ctl = 5'b10000; alu = 4'd10; end
      7'h17: ctl = 5'b10000;
      default: ;
    endcase
    return {ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[31:25],
            ii, is, ib, iu, ij, ctl, alu};
  endfunction

  vec_t act_v, exp_v;
  logic have_exp = 1'b0;
  assign act_v = {opcode, rd, funct3, rs1, rs2, funct7, imm_I, imm_S, imm_B,
                  imm_U, imm_J, reg_write, mem_read, mem_write, branch, jump, alu_op};

  // Prediction follows the inputs seen at each rising edge.
  always @(posedge clk) begin
    exp_v    = model(instruction, rst_n);
    have_exp = 1'b1;
  end

  always @(negedge clk) begin
    if (have_exp) begin
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t actual %h required %h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Present an instruction, then sample just after the capturing edge.
  task automatic drive(input logic [31:0] ins, input logic rstn);
    @(negedge clk);
    instruction = ins;
    rst_n       = rstn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(32'hFFFF_FFFF, 1'b0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_imm_J", imm_J, 0);
    chk("rst_ctl", 32'({reg_write, mem_read, mem_write, branch, jump, alu_op}), 0);

    drive(32'h0031_00B3, 1'b1);            // add x1,x2,x3
    chk("add_opcode", 32'(opcode), 32'h33);
    chk("add_regs", 32'({rd, rs1, rs2}), 32'({5'd1, 5'd2, 5'd3}));
    chk("add_ctl", 32'({reg_write, mem_read, mem_write, branch, jump, alu_op}), 32'h100);
    drive(32'h4031_00B3, 1'b1);            // sub
    chk("sub_alu", 32'(alu_op), 1);
    drive(32'h0051_0093, 1'b1);            // addi x1,x2,5
    chk("addi_imm", imm_I, 5);
    chk("addi_ctl", 32'({reg_write, alu_op}), 32'h10);
    drive(32'h0081_2083, 1'b1);            // lw x1,8(x2)
    chk("lw_f3", 32'(funct3), 2);
    chk("lw_imm", imm_I, 8);
    chk("lw_ctl", 32'({reg_write, mem_read, mem_write}), 32'b110);
    drive(32'h0031_2623, 1'b1);            // sw x3,12(x2)
    chk("sw_imm", imm_S, 12);
    chk("sw_ctl", 32'({rs2, reg_write, mem_write}), 32'({5'd3, 2'b01}));
    drive(32'h0020_8863, 1'b1);            // beq x1,x2,16
    chk("beq_imm", imm_B, 16);
    chk("beq_ctl", 32'({reg_write, branch, alu_op}), 32'h11);
    drive(32'h0200_00EF, 1'b1);            // jal x1,32
    chk("jal_imm", imm_J, 32);
    chk("jal_ctl", 32'({reg_write, jump}), 3);
    drive(32'h0001_00E7, 1'b1);            // jalr x1,0(x2)
    chk("jalr", 32'({imm_I[7:0], rs1, reg_write, jump}), 32'({8'd0, 5'd2, 2'b11}));
    drive(32'h1234_50B7, 1'b1);            // lui x1,0x12345
    chk("lui_imm", imm_U, 32'h1234_5000);
    chk("lui_ctl", 32'({reg_write, alu_op}), 32'h1A);
    drive(32'hFFF0_0093, 1'b1);            // addi x1,x0,-1
    chk("neg_imm", imm_I, 32'hFFFF_FFFF);
    drive(32'hFFFF_FFFF, 1'b1);            // unknown opcode
    chk("bad_ctl", 32'({reg_write, mem_read, mem_write, branch, jump, alu_op}), 0);
    chk("bad_imm_B", imm_B, 32'hFFFF_FFFE);

    drive(32'h0031_00B3, 1'b0);            // reset mid-stream
    chk("mid_rst", 32'({opcode, reg_write}), 0);
    drive(32'h0031_00B3, 1'b1);
    chk("resume", 32'({opcode, reg_write}), 32'({7'h33, 1'b1}));

    // Every funct3 for R, I and branch with funct7[5] set; mixed sign bits.
    for (int f = 0; f < 8; f++) begin
      drive({7'b0100000, 5'd7, 5'd9, 3'(f), 5'd4, 7'h33}, 1'b1);
      drive({7'b0100000, 5'd7, 5'd9, 3'(f), 5'd4, 7'h13}, 1'b1);
      drive({7'b1010101, 5'd7, 5'd9, 3'(f), 5'd4, 7'h63}, 1'b1);
    end
    drive(32'h8000_0017, 1'b1);            // auipc, negative upper
    drive(32'hFE01_0FA3, 1'b1);            // store with negative offset
    drive(32'h8000_006F, 1'b1);            // jal, most negative offset
    drive(32'h0000_0000, 1'b1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruct_decoder.md
Name: instruct_decoder

Overview:
- RV32I instruction decoder in the core's decode stage.
- Splits a 32-bit instruction into register/function fields and all five sign-extended immediate formats.
- Generates datapath control: reg_write, mem_read, mem_write, alu_op, branch, jump.
- All outputs are registered: the decode is latched one clock after the instruction is presented.

Parameters:
- None; XLEN fixed at 32.

Ports:
- clk          input   1   system clock, rising-edge active
- rst_n        input   1   synchronous active-low reset
- instruction  input   32  instruction word to decode
- opcode       output  7   instruction[6:0]
- rd           output  5   instruction[11:7]
- funct3       output  3   instruction[14:12]
- rs1          output  5   instruction[19:15]
- rs2          output  5   instruction[24:20]
- funct7       output  7   instruction[31:25]
- imm_I        output  32  I-type immediate, sign-extended
- imm_S        output  32  S-type immediate, sign-extended
- imm_B        output  32  B-type immediate, sign-extended, bit0=0
- imm_U        output  32  U-type immediate, low 12 bits zero
- imm_J        output  32  J-type immediate, sign-extended, bit0=0
- reg_write    output  1   write rd
- mem_read     output  1   load
- mem_write    output  1   store
- alu_op       output  4   ALU operation code
- branch       output  1   conditional branch
- jump         output  1   JAL/JALR

Behaviour:
Timing and reset
- One clock; reset is synchronous and active-low.
- rst_n sampled low at a rising edge: every output becomes 0 at that edge.
- Otherwise, each rising edge registers the combinational decode of the current instruction. Latency is exactly 1 cycle.
- No handshake; a new instruction is accepted every cycle.
- Reset asserted mid-stream discards the in-flight decode.

Field extraction
- Field and immediate outputs are extracted unconditionally, whatever the opcode.
- imm_I = sext(instr[31:20])
- imm_S = sext({instr[31:25], instr[11:7]})
- imm_B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
- imm_U = {instr[31:12], 12'b0}
- imm_J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})

alu_op encoding
- 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR
- 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B

Decode by opcode
- 0110011 (R-type): reg_write=1.
  - alu_op from funct3: 000 gives ADD, or SUB when funct7[5]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 gives SRL, or SRA when funct7[5]=1.
  - 110 OR, 111 AND.
- 0010011 (I-ALU): reg_write=1; same funct3 map as R-type, except 000 is always ADD (funct7 ignored). 101 uses funct7[5] to select SRAI.
- 0000011 (load): reg_write=1, mem_read=1, alu_op=ADD.
- 0100011 (store): mem_write=1, alu_op=ADD.
- 1100011 (branch): branch=1.
  - alu_op is SUB for funct3 000/001.
  - SLT for 100/101.
  - SLTU for 110/111.
  - ADD for reserved 010/011.
- 1101111 (JAL) and 1100111 (JALR): reg_write=1, jump=1, alu_op=ADD.
- 0110111 (LUI): reg_write=1, alu_op=PASS_B.
- 0010111 (AUIPC): reg_write=1, alu_op=ADD.
- Any other opcode: all control outputs 0, alu_op=0000. Fields and immediates are still driven.

Other rules
- reg_write follows the opcode even when rd=0; the register file ignores writes to x0.
- At most one of mem_read, mem_write, branch, jump is 1 in any cycle.

Test Plan:
- Reset: hold rst_n=0 one edge with any instruction → all outputs 0. Release, apply 0x003100B3 (add x1,x2,x3) → next edge: opcode=0110011, rd=1, rs1=2, rs2=3, reg_write=1, alu_op=0000, others 0. Then 0x403100B3 → alu_op=0001.
- 0x00510093 (addi x1,x2,5) → imm_I=5, reg_write=1, alu_op=0000. 0x00812083 (lw x1,8(x2)) → funct3=010, imm_I=8, mem_read=1, reg_write=1.
- 0x00312623 (sw x3,12(x2)) → imm_S=12, rs2=3, mem_write=1, reg_write=0. 0x00208863 (beq x1,x2,16) → imm_B=16, branch=1, alu_op=0001, reg_write=0.
- 0x020000EF (jal x1,32) → imm_J=32, jump=1, reg_write=1. 0x000100E7 (jalr x1,0(x2)) → imm_I=0, rs1=2, jump=1, reg_write=1.
- 0x123450B7 (lui x1,0x12345) → imm_U=0x12345000, alu_op=1010, reg_write=1. 0xFFF00093 (addi x1,x0,-1) → imm_I=0xFFFFFFFF.
- Opcode 1111111 → all controls 0. Drop rst_n low while decoding add → outputs 0 at that edge; decode resumes the cycle after release.
